// File: rtl/gemm_pkg.sv
// Shared GEMM datapath definitions.
// Holds the IPU in-flight tag type and the helper that gives the IPU pipeline depth
// for a given vector length.
package gemm_pkg;

    // Travels beside each operand pair through the IPU pipeline.
    // v: valid issue, f: first chunk of an element, l: last chunk of an element.
    typedef struct packed {
        logic v;
        logic f;
        logic l;
    } ipu_tag_t;

    // Enabled cycles from operand issue to valid IPU output:
    // one input flip-flop stage plus one stage per adder-tree level.
    function automatic int ipu_latency(input int vector_len);
        return 32'sd1 + $clog2(vector_len);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Result FIFO: first-word fall-through buffer with a registered occupancy count.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push       write push_data (ignored when full)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   head_data  current head entry, valid whenever !empty
//   empty      count == 0
//   full       count == DEPTH
//   count      number of stored entries
module result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      head_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Qualify requests against the registered occupancy.
    always_comb begin
        push_ok_s = push && (count_r != CNT_MAX);
        pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    end

    // Storage array; data needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers (wrap naturally since DEPTH is a power of two) and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_MAX);
    assign count     = count_r;

endmodule

// File: rtl/ipu_psum_accumulator.sv
// IPU partial-sum accumulator.
// Follows every operand-pair issue through the IPU with a tag shift register that
// moves in lockstep with the IPU enable, sums chunked partial dot products into one
// result per output element, and queues finished results in a small FIFO.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid/first/last   operand-pair issue and its chunk position
//   issue_ready              issue accepted when high (same as ipu_enable)
//   ipu_enable               advance enable for the IPU pipeline
//   ipu_data                 IPU result aligned with the tail tag
//   out_valid/ready/data     result stream (valid/ready)
//   proto_err                sticky first/last sequencing error
//   busy                     work in flight, accumulation open or results queued
module ipu_psum_accumulator
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int VECTOR_LEN  = 32,
    parameter int IPU_LATENCY = ipu_latency(VECTOR_LEN),
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_first,
    input  logic                  issue_last,
    output logic                  issue_ready,
    output logic                  ipu_enable,
    input  logic [DATA_WIDTH-1:0] ipu_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  proto_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ipu_tag_t              tag_r [IPU_LATENCY];
    ipu_tag_t              tail_s;
    logic [DATA_WIDTH-1:0] acc_r;
    logic                  acc_open_r;
    logic                  proto_err_r;
    logic [DATA_WIDTH-1:0] sum_s;
    logic                  enable_s;
    logic                  consume_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  tags_busy_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [DATA_WIDTH-1:0] fifo_head_s;

    assign tail_s = tag_r[IPU_LATENCY-1];

    // Stall and datapath control. fifo_full_s ignores a same-cycle pop so that
    // out_ready never reaches ipu_enable combinationally; the price is one bubble.
    always_comb begin
        if (fifo_full_s && tail_s.v && tail_s.l) begin
            enable_s = 1'b0;
        end else begin
            enable_s = 1'b1;
        end
        consume_s = tail_s.v && enable_s;
        push_s    = consume_s && tail_s.l;
        pop_s     = out_ready && !fifo_empty_s;
        if (tail_s.f) begin
            sum_s = ipu_data;
        end else begin
            sum_s = acc_r + ipu_data;
        end
    end

    // Any valid tag still inside the IPU pipeline.
    always_comb begin
        tags_busy_s = 1'b0;
        for (int i = 0; i < IPU_LATENCY; i++) begin
            tags_busy_s = tags_busy_s | tag_r[i].v;
        end
    end

    // Tag shift register; holds whenever the IPU is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IPU_LATENCY; i++) begin
                tag_r[i] <= ipu_tag_t'(3'b000);
            end
        end else if (enable_s) begin
            tag_r[0] <= '{v: issue_valid, f: issue_first, l: issue_last};
            for (int i = 1; i < IPU_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end else begin
            for (int i = 0; i < IPU_LATENCY; i++) begin
                tag_r[i] <= tag_r[i];
            end
        end
    end

    // Accumulator and sticky protocol check, updated only when the tail is consumed.
    // A first chunk while open, or a continuation while closed, is flagged but still
    // processed so the datapath never wedges.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {DATA_WIDTH{1'b0}};
            acc_open_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else if (consume_s) begin
            acc_r      <= sum_s;
            acc_open_r <= !tail_s.l;
            if (tail_s.f == acc_open_r) begin
                proto_err_r <= 1'b1;
            end
        end else begin
            acc_r      <= acc_r;
            acc_open_r <= acc_open_r;
        end
    end

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (sum_s),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    assign ipu_enable  = enable_s;
    assign issue_ready = enable_s;
    assign out_valid   = !fifo_empty_s;
    assign out_data    = fifo_head_s;
    assign proto_err   = proto_err_r;
    assign busy        = tags_busy_s || acc_open_r || (fifo_count_s != {CNT_W{1'b0}});

endmodule

// File: tb/tb_ipu_psum_accumulator.sv
// Directed bench for ipu_psum_accumulator. A small behavioural IPU (enabled delay
// line carrying a chosen value per issue) feeds ipu_data; results are collected
// from the valid/ready stream and compared with hand-computed values.
module tb_ipu_psum_accumulator;

    localparam int DW  = 32;
    localparam int LAT = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_first = 1'b0;
    logic          issue_last = 1'b0;
    logic          issue_ready;
    logic          ipu_enable;
    logic [DW-1:0] ipu_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          proto_err;
    logic          busy;

    logic [DW-1:0] issue_value = 32'h0;
    logic [DW-1:0] ipu_pipe [LAT];
    logic [DW-1:0] obs [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            accepted = 0;
    logic          stall_seen = 1'b0;

    ipu_psum_accumulator #(
        .DATA_WIDTH (DW),
        .VECTOR_LEN (32),
        .IPU_LATENCY(LAT),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_first(issue_first),
        .issue_last (issue_last),
        .issue_ready(issue_ready),
        .ipu_enable (ipu_enable),
        .ipu_data   (ipu_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .proto_err  (proto_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural IPU: value travels LAT enabled cycles, then appears on ipu_data.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < LAT; i++) ipu_pipe[i] <= 32'h0;
        end else if (ipu_enable) begin
            ipu_pipe[0] <= issue_valid ? issue_value : 32'h0;
            for (int i = 1; i < LAT; i++) ipu_pipe[i] <= ipu_pipe[i-1];
        end
        if (!rst && issue_valid && issue_ready) accepted <= accepted + 1;
        if (!rst && out_valid && out_ready) obs.push_back(out_data);
    end
    assign ipu_data = ipu_pipe[LAT-1];

    // Stall observer.
    always @(negedge clk) begin
        if (!rst && !ipu_enable) stall_seen <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one issue; hold it until accepted (bounded).
    task automatic issue(input logic f, input logic l, input logic [DW-1:0] v);
        int tries;
        tries = 0;
        issue_valid = 1'b1;
        issue_first = f;
        issue_last  = l;
        issue_value = v;
        while (!issue_ready && tries < 50) begin
            idle(1);
            tries++;
        end
        if (tries >= 50) check_eq("issue_timeout", tries, 0);
        idle(1);
        issue_valid = 1'b0;
        issue_first = 1'b0;
        issue_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 200) begin
            idle(1);
            t++;
        end
        check_eq("drain", busy, 1'b0);
    endtask

    initial begin
        int start;
        int acc0;
        logic ready_drop;

        idle(3);
        rst = 1'b0;
        #2;
        // Reset state
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_proto_err", proto_err, 1'b0);
        check_eq("rst_ipu_enable", ipu_enable, 1'b1);
        check_eq("rst_issue_ready", issue_ready, 1'b1);
        idle(1);

        // Single-chunk latency
        out_ready = 1'b1;
        ready_drop = 1'b0;
        start = cyc;
        issue(1'b1, 1'b1, 32'h0000_0123);
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                if (!issue_ready) ready_drop = 1'b1;
                t++;
            end while (!out_valid && t < 30);
        end
        check_eq("single_latency", cyc - start, 7);
        check_eq("single_data", out_data, 32'h0000_0123);
        check_eq("single_ready", ready_drop, 1'b0);
        idle(1);
        wait_idle();
        check_eq("single_count", obs.size(), 1);
        obs.delete();

        // Three-chunk element with a bubble and wrap-around
        issue(1'b1, 1'b0, 32'h0000_0005);
        issue(1'b0, 1'b0, 32'h0000_0007);
        idle(1);
        issue(1'b0, 1'b1, 32'hFFFF_FFFF);
        wait_idle();
        check_eq("multi_count", obs.size(), 1);
        if (obs.size() > 0) check_eq("multi_data", obs[0], 32'h0000_000B);
        check_eq("multi_proto", proto_err, 1'b0);
        obs.delete();

        // Back-pressure: FIFO fills, IPU stalls on element 5
        out_ready = 1'b0;
        stall_seen = 1'b0;
        acc0 = accepted;
        for (int i = 1; i <= 6; i++) issue(1'b1, 1'b1, 32'(i));
        idle(8);
        check_eq("bp_stalled", ipu_enable, 1'b0);
        check_eq("bp_head_valid", out_valid, 1'b1);
        check_eq("bp_head_data", out_data, 32'h0000_0001);
        check_eq("bp_fifo_count", 32'(dut.fifo_count_s), 32'd4);
        out_ready = 1'b1;
        wait_idle();
        check_eq("bp_stall_seen", stall_seen, 1'b1);
        check_eq("bp_accepted", accepted - acc0, 6);
        check_eq("bp_count", obs.size(), 6);
        for (int i = 0; i < obs.size() && i < 6; i++) check_eq("bp_order", obs[i], 32'(i + 1));
        obs.delete();

        // Simultaneous push/pop at count 2
        out_ready = 1'b0;
        stall_seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) issue(1'b1, 1'b1, 32'h10 + 32'(i));
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    check_eq("pp_count", 32'(dut.fifo_count_s), 32'd2);
                    check_eq("pp_enable", ipu_enable, 1'b1);
                end
            end
        join
        wait_idle();
        check_eq("pp_stall_seen", stall_seen, 1'b0);
        check_eq("pp_total", obs.size(), 10);
        for (int i = 0; i < obs.size() && i < 10; i++) check_eq("pp_order", obs[i], 32'h10 + 32'(i));
        obs.delete();

        // Protocol error: first while open
        issue(1'b1, 1'b0, 32'h0000_0004);
        issue(1'b1, 1'b1, 32'h0000_0009);
        wait_idle();
        check_eq("perr_flag", proto_err, 1'b1);
        check_eq("perr_count", obs.size(), 1);
        if (obs.size() > 0) check_eq("perr_data", obs[0], 32'h0000_0009);
        obs.delete();
        issue(1'b1, 1'b1, 32'h0000_0055);
        wait_idle();
        check_eq("perr_sticky", proto_err, 1'b1);
        if (obs.size() > 0) check_eq("perr_next", obs[0], 32'h0000_0055);
        else check_eq("perr_next_count", obs.size(), 1);
        obs.delete();

        // Reset mid-operation: 2 queued, 3 in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) issue(1'b1, 1'b1, 32'hA1 + 32'(i));
        idle(3);
        check_eq("mid_fifo_count", 32'(dut.fifo_count_s), 32'd2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        #1;
        check_eq("mid_out_valid", out_valid, 1'b0);
        check_eq("mid_busy", busy, 1'b0);
        check_eq("mid_proto_err", proto_err, 1'b0);
        out_ready = 1'b1;
        idle(20);
        check_eq("mid_no_stale", obs.size(), 0);
        issue(1'b1, 1'b1, 32'h0000_0777);
        wait_idle();
        check_eq("post_rst_count", obs.size(), 1);
        if (obs.size() > 0) check_eq("post_rst_data", obs[0], 32'h0000_0777);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ipu_psum_accumulator.md
Name: ipu_psum_accumulator

Overview:
- Downstream stage of the inner-product unit (IPU) in the GEMM datapath.
- Tracks each operand-pair issue through the IPU's fixed pipeline with a tag shift register. Accumulates chunked partial dot products (K = chunks x VECTOR_LEN) into one result per output element.
- Buffers finished results in a small FIFO with a valid/ready output.
- Drives the IPU enable, stalling the whole IPU pipeline when the result FIFO cannot absorb a completing element.

Parameters:
- DATA_WIDTH, 32, width of IPU result, accumulator and output data.
- VECTOR_LEN, 32, IPU vector length; informational, used only to derive the IPU_LATENCY default.
- IPU_LATENCY, 6, enabled cycles from operand issue to valid IPU data_out (1 flip-flop stage + clog2(VECTOR_LEN) adder-tree stages); must be >= 1.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  upstream presents an operand pair to the IPU this cycle.
- issue_first  in  1  pair is the first chunk of an output element.
- issue_last  in  1  pair is the last chunk of an output element (first and last both set = single-chunk element).
- issue_ready  out  1  issue accepted when issue_valid && issue_ready; equals ipu_enable.
- ipu_enable  out  1  enable to IPU flip-flop array and adder tree.
- ipu_data  in  DATA_WIDTH  IPU data_out.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  DATA_WIDTH  head result.
- proto_err  out  1  sticky protocol-error flag.
- busy  out  1  any tag in flight, accumulation open, or FIFO non-empty.

Behaviour:
- Reset: tag pipe cleared, acc = 0, acc_open = 0, FIFO empty, out_valid = 0, proto_err = 0, busy = 0. ipu_enable = 1 in the cycle after reset.
- Tag pipe: IPU_LATENCY stages of {v, f, l}. Stage 0 loads {issue_valid, issue_first, issue_last}. Shifts only when ipu_enable = 1; holds otherwise, in lockstep with the IPU.
- Tail = last stage. The tail is consumed when tail.v && ipu_enable.
- Stall: ipu_enable = !(fifo_full && tail.v && tail.l).
  - fifo_full is a registered count compare and does not include a same-cycle pop. This avoids a combinational path from out_ready to ipu_enable.
  - Cost: one bubble cycle when the FIFO is full, even if the head is popped in that cycle.
- Accumulate on consume:
  - sum = tail.f ? ipu_data : acc + ipu_data, modulo 2^DATA_WIDTH; overflow wraps, no saturation.
  - acc <= sum.
  - acc_open <= !tail.l.
  - If tail.l, push sum into the FIFO.
- Protocol errors (set proto_err, cleared only by rst):
  - tail.f while acc_open. Still restart acc from ipu_data.
  - !tail.f while !acc_open. Still accumulate onto the current acc.
- Bubbles (tail.v = 0): acc and acc_open unchanged; an element may span arbitrary gaps.
- FIFO: first-word fall-through, registered count.
  - Push and pop in the same cycle is legal; count unchanged.
  - Push is never attempted when full (guaranteed by the stall).
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a single-chunk element issued at cycle t with no stall gives out_valid at t + IPU_LATENCY + 1.
- out_data is stable while out_valid && !out_ready.
- Reset mid-operation: all in-flight tags, open accumulation and FIFO contents are discarded. The IPU registers are reset by the same rst.

Decomposition:
- Shared package gemm_pkg holds:
  - typedef ipu_tag_t {logic v; logic f; logic l;};
  - function ipu_latency(vector_len) = 1 + $clog2(vector_len), used for the IPU_LATENCY default.
- One sub-module: result_fifo (DATA_WIDTH, DEPTH; push, push_data, pop, head_data, empty, full, count).
- Tag pipe, accumulator and stall logic are inline.

Test Plan:
- Single-chunk: IPU_LATENCY = 6; issue {f = 1, l = 1} at cycle 10, model ipu_data = 0x0000_0123 at the tail -> out_valid at cycle 17, out_data = 0x123, issue_ready stays 1.
- Three-chunk element: partial sums 5, 7, 0xFFFF_FFFF with tags f, -, l and one idle bubble between chunks 2 and 3 -> exactly one output, 0x0000_000B (wrap); no proto_err.
- Back-pressure: out_ready = 0, issue 6 single-chunk elements of values 1..6 back-to-back (FIFO_DEPTH = 4) -> FIFO holds 1..4, ipu_enable drops when element 5 reaches the tail. Raise out_ready -> outputs 1..6 in order, none lost or duplicated, each issue accepted exactly once.
- Simultaneous push/pop with FIFO at count 2 over 8 cycles with out_ready = 1 -> count stays 2, order preserved, ipu_enable stays 1.
- Protocol error: issue {f = 1, l = 0} then {f = 1, l = 1}, values 4 and 9 -> proto_err = 1 and stays set, output = 9.
- Reset mid-operation: assert rst for 1 cycle with 3 tags in flight and 2 FIFO entries -> next cycle out_valid = 0, busy = 0, proto_err = 0, no stale outputs ever appear.
